divide_algo: RTL and testbench

- Free-running sequential unsigned integer divider.
- Continuously samples a dividend/divisor pair, computes quotient and remainder with a restoring shift-subtract algorithm (one quotient bit per clock), then publishes the results on registered outputs.
- Has no start/done handshake; results refresh every WIDTH+2 clocks.
- Used as the arithmetic divide helper in the datapath.

---
 rtl/divide_algo.sv | 78 +++++++
 tb/tb_divide_algo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/divide_algo.sv
// Free-running restoring divider: samples dividend/divider, resolves one quotient
// bit per clock, and republishes quo/rem every WIDTH+2 clocks.
module divide_algo #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divider,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r;
  logic [CW-1:0]    cnt;
  logic [WIDTH+1:0] rshift;
  logic [WIDTH+1:0] diff;

  // One extra guard bit above the shifted remainder makes diff's MSB a clean borrow flag.
  assign rshift = {r, q[WIDTH-1]};
  assign diff   = rshift - {2'b00, d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    next_state = CALC;
      CALC:    if (cnt == LAST) next_state = DONE;
      DONE:    next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      d   <= '0;
      r   <= '0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
    end else begin
      case (state)
        LOAD: begin
          q   <= dividend;
          d   <= divider;
          r   <= '0;
          cnt <= '0;
        end
        CALC: begin
          // A borrow means the trial subtraction failed: keep the shifted remainder.
          q   <= {q[WIDTH-2:0], ~diff[WIDTH+1]};
          r   <= diff[WIDTH+1] ? rshift[WIDTH:0] : diff[WIDTH:0];
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          quo <= q;
          rem <= r[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_algo.sv
// Directed bench for divide_algo: hand-computed vectors, latency, hold,
// mid-operation operand change, async reset abort, and a randomized identity sweep.
module tb_divide_algo;

  logic        clk;
  logic        rst;
  logic [15:0] dividend;
  logic [15:0] divider;
  logic [15:0] quo;
  logic [15:0] rem;

  int checks   = 0;
  int failures = 0;

  divide_algo #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .dividend (dividend),
    .divider  (divider),
    .quo      (quo),
    .rem      (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divider  = b;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive operands just before a LOAD edge, then check after the DONE edge 18 edges later.
  task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er);
    applyStimulus(a, b);
    waitEdges(18);
    checkOutput({tag, "_quo"}, {16'h0, quo}, {16'h0, eq});
    checkOutput({tag, "_rem"}, {16'h0, rem}, {16'h0, er});
  endtask

  logic [15:0] ra, rb;
  logic [31:0] prod;

  initial begin
    rst = 1'b0;
    applyStimulus(16'd0, 16'd0);
    #30;
    checkOutput("reset_quo_early", {16'h0, quo}, 32'h0);
    checkOutput("reset_rem_early", {16'h0, rem}, 32'h0);
    #67;
    checkOutput("reset_quo_late", {16'h0, quo}, 32'h0);
    checkOutput("reset_rem_late", {16'h0, rem}, 32'h0);
    #3;
    rst = 1'b1;

    // First LOAD is the first edge after release; result lands on edge 18.
    applyStimulus(16'd4, 16'd2);
    waitEdges(17);
    checkOutput("latency_pre_quo", {16'h0, quo}, 32'h0);
    waitEdges(1);
    checkOutput("first_quo", {16'h0, quo}, 32'd2);
    checkOutput("first_rem", {16'h0, rem}, 32'd0);

    applyStimulus(16'd100, 16'd7);
    waitEdges(9);
    checkOutput("hold_quo", {16'h0, quo}, 32'd2);
    checkOutput("hold_rem", {16'h0, rem}, 32'd0);
    waitEdges(9);
    checkOutput("d100_7_quo", {16'h0, quo}, 32'd14);
    checkOutput("d100_7_rem", {16'h0, rem}, 32'd2);

    runOp("ffff_1",    16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000);
    runOp("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000);
    runOp("d3_10",     16'd3,    16'd10,   16'd0,    16'd3);
    runOp("div0",      16'd5,    16'd0,    16'hFFFF, 16'd5);
    runOp("zero_div0", 16'd0,    16'd0,    16'hFFFF, 16'd0);
    runOp("zero_num",  16'd0,    16'd9,    16'd0,    16'd0);
    runOp("d1000_33",  16'd1000, 16'd33,   16'd30,   16'd10);

    // Operand change mid-CALC must not disturb the in-flight division.
    applyStimulus(16'd4, 16'd2);
    waitEdges(6);
    applyStimulus(16'd9, 16'd4);
    waitEdges(12);
    checkOutput("midchg_quo", {16'h0, quo}, 32'd2);
    checkOutput("midchg_rem", {16'h0, rem}, 32'd0);
    waitEdges(18);
    checkOutput("next_quo", {16'h0, quo}, 32'd2);
    checkOutput("next_rem", {16'h0, rem}, 32'd1);

    // Asynchronous reset between edges in the middle of CALC.
    applyStimulus(16'd50, 16'd6);
    waitEdges(7);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort_quo", {16'h0, quo}, 32'h0);
    checkOutput("abort_rem", {16'h0, rem}, 32'h0);
    #10;
    rst = 1'b1;
    applyStimulus(16'd100, 16'd7);
    waitEdges(17);
    checkOutput("rerun_pre_quo", {16'h0, quo}, 32'h0);
    waitEdges(1);
    checkOutput("rerun_quo", {16'h0, quo}, 32'd14);
    checkOutput("rerun_rem", {16'h0, rem}, 32'd2);

    // Random sweep: check the division identity and remainder bound.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(1, 65535));
      applyStimulus(ra, rb);
      waitEdges(18);
      prod = {16'h0, quo} * {16'h0, rb} + {16'h0, rem};
      checkOutput("rand_identity", prod, {16'h0, ra});
      checkOutput("rand_rem_lt", {31'h0, (rem < rb)}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
